hazard_stall_unit: RTL

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

---
 rtl/hazard_stall_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use / BEQ operand hazard detection driving PC, IF/ID, ID/EXE and freeze controls.
// Latency: stall controls are combinational; a BEQ behind a load in EXE adds one registered HOLD cycle.
// Backpressure: mem_busy freezes the pipe and holds the FSM; HAZARD_STAT_EN adds a saturating stall counter.
`ifndef OP_BEQ
`define OP_BEQ 6'b000100
`endif

module hazard_stall_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs_ID,
    input  logic [4:0]  rt_ID,
    input  logic [5:0]  op_ID,
    input  logic        uses_rt_ID,
    input  logic [4:0]  num_write_EXE,
    input  logic        reg_write_EXE,
    input  logic        mem_read_EXE,
    input  logic [4:0]  num_write_MEM,
    input  logic        mem_read_MEM,
    input  logic        branch_taken_ID,
    input  logic        mem_busy,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_exe_bubble,
    output logic        if_id_flush,
    output logic        pipe_freeze,
    output logic [15:0] stall_cnt
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic is_beq;
    logic exe_hit_rs;
    logic exe_hit_rt;
    logic mem_hit_rs;
    logic mem_hit_rt;
    logic load_use;
    logic br_alu;
    logic br_ld_exe;
    logic br_ld_mem;
    logic need1;
    logic need2;
    logic stall;

    // Register 0 is hard-wired zero, so it can never carry a real dependency.
    function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

    always_comb begin
        is_beq     = (op_ID == `OP_BEQ);
        exe_hit_rs = reg_hit(num_write_EXE, rs_ID);
        exe_hit_rt = reg_hit(num_write_EXE, rt_ID);
        mem_hit_rs = reg_hit(num_write_MEM, rs_ID);
        mem_hit_rt = reg_hit(num_write_MEM, rt_ID);

        load_use  = mem_read_EXE && (exe_hit_rs || (uses_rt_ID && exe_hit_rt));
        br_alu    = is_beq && reg_write_EXE && !mem_read_EXE && (exe_hit_rs || exe_hit_rt);
        br_ld_exe = is_beq && mem_read_EXE && (exe_hit_rs || exe_hit_rt);
        br_ld_mem = is_beq && mem_read_MEM && (mem_hit_rs || mem_hit_rt);

        need1 = load_use || br_alu || br_ld_mem;
        need2 = br_ld_exe;
    end

    // HOLD stalls blindly: the load is already in MEM and its data is not yet usable by BEQ.
    always_comb begin
        stall = 1'b0;
        if (state_q == HOLD) begin
            stall = 1'b1;
        end else begin
            stall = need1 || need2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!mem_busy) begin
            case (state_q)
                RUN:     state_d = need2 ? HOLD : RUN;
                HOLD:    state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_exe_bubble = 1'b0;
        if_id_flush   = 1'b0;
        pipe_freeze   = 1'b0;
        if (!rst_n) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_exe_bubble = 1'b1;
        end else if (mem_busy) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            pipe_freeze   = 1'b1;
        end else if (stall) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_exe_bubble = 1'b1;
        end else begin
            if_id_flush   = branch_taken_ID;
        end
    end

`ifdef HAZARD_STAT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'd0;
        end else if (id_exe_bubble && !pipe_freeze && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule
